// File: rtl/bus_pkg.sv
// Shared definitions for the instruction/data bus arbiter: widths, state codes and the
// registered memory-request payload.
package bus_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 4;
  localparam int unsigned CNT_W  = 4;

  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_BUSY_FETCH = 2'd1;
  localparam logic [1:0] ST_BUSY_DATA  = 2'd2;
  localparam logic [1:0] ST_DONE       = 2'd3;

  localparam logic [STRB_W-1:0] READ_STROBE = 4'b0000;

  typedef struct packed {
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] strobe;
  } mem_req_t;

endpackage

// File: rtl/bus_arbiter.sv
// Arbitrates one external memory port between instruction fetch and load/store, with a
// bounded data burst while a fetch waits and support for discarding an in-flight fetch.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int unsigned MAX_DATA_BURST = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_address,
  input  logic              fetch_cancel,
  output logic [DATA_W-1:0] fetch_data,
  output logic              fetch_ready,
  input  logic              data_req,
  input  logic              data_write,
  input  logic [ADDR_W-1:0] data_address,
  input  logic [DATA_W-1:0] data_wdata,
  input  logic [STRB_W-1:0] data_strobe,
  output logic [DATA_W-1:0] data_rdata,
  output logic              data_ready,
  output logic              mem_valid,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [STRB_W-1:0] mem_strobe,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_DATA_BURST);

  logic [1:0]        state_q, state_n;
  mem_req_t          req_q, req_n;
  logic              mem_valid_n;
  logic              write_q, write_n;
  logic              cancel_q, cancel_n;
  logic [CNT_W-1:0]  burst_cnt, burst_cnt_n;
  logic              fetch_ready_n, data_ready_n;
  logic [DATA_W-1:0] fetch_data_n, data_rdata_n;
  logic              grant_data_c, grant_fetch_c;

  assign mem_address = req_q.address;
  assign mem_wdata   = req_q.wdata;
  assign mem_strobe  = req_q.strobe;

  // State and all output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      req_q       <= '0;
      mem_valid   <= 1'b0;
      write_q     <= 1'b0;
      cancel_q    <= 1'b0;
      burst_cnt   <= '0;
      fetch_ready <= 1'b0;
      data_ready  <= 1'b0;
      fetch_data  <= '0;
      data_rdata  <= '0;
    end else begin
      state_q     <= state_n;
      req_q       <= req_n;
      mem_valid   <= mem_valid_n;
      write_q     <= write_n;
      cancel_q    <= cancel_n;
      burst_cnt   <= burst_cnt_n;
      fetch_ready <= fetch_ready_n;
      data_ready  <= data_ready_n;
      fetch_data  <= fetch_data_n;
      data_rdata  <= data_rdata_n;
    end
  end

  // Next-state, grant and completion logic
  always_comb begin
    state_n       = state_q;
    req_n         = req_q;
    mem_valid_n   = mem_valid;
    write_n       = write_q;
    cancel_n      = cancel_q;
    burst_cnt_n   = burst_cnt;
    fetch_ready_n = 1'b0;
    data_ready_n  = 1'b0;
    fetch_data_n  = fetch_data;
    data_rdata_n  = data_rdata;
    // Data wins ties until it has used up its burst allowance against a waiting fetch
    grant_data_c  = data_req && !(fetch_req && (burst_cnt == BURST_MAX));
    grant_fetch_c = fetch_req && !grant_data_c;

    case (state_q)
      ST_IDLE: begin
        if (grant_data_c) begin
          state_n       = ST_BUSY_DATA;
          mem_valid_n   = 1'b1;
          write_n       = data_write;
          req_n.address = data_address;
          req_n.wdata   = data_write ? data_wdata : '0;
          req_n.strobe  = data_write ? data_strobe : READ_STROBE;
          if (!fetch_req) begin
            burst_cnt_n = '0;
          end else if (burst_cnt != BURST_MAX) begin
            burst_cnt_n = burst_cnt + CNT_W'(1);
          end
        end else if (grant_fetch_c) begin
          state_n       = ST_BUSY_FETCH;
          mem_valid_n   = 1'b1;
          write_n       = 1'b0;
          req_n.address = fetch_address;
          req_n.wdata   = '0;
          req_n.strobe  = READ_STROBE;
          burst_cnt_n   = '0;
          cancel_n      = fetch_cancel;
        end
      end

      ST_BUSY_FETCH: begin
        if (fetch_cancel) begin
          cancel_n = 1'b1;
        end
        if (mem_ready) begin
          state_n      = ST_DONE;
          mem_valid_n  = 1'b0;
          req_n.strobe = READ_STROBE;
          // A cancel arriving in the completion cycle still discards the word
          if (!(cancel_q || fetch_cancel)) begin
            fetch_ready_n = 1'b1;
            fetch_data_n  = mem_rdata;
          end
        end
      end

      ST_BUSY_DATA: begin
        if (mem_ready) begin
          state_n      = ST_DONE;
          mem_valid_n  = 1'b0;
          req_n.strobe = READ_STROBE;
          data_ready_n = 1'b1;
          if (!write_q) begin
            data_rdata_n = mem_rdata;
          end
        end
      end

      ST_DONE: begin
        state_n  = ST_IDLE;
        cancel_n = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: a transaction-level reference model predicts bus
// accesses and ready pulses; a monitor compares them against the DUT as they appear.
module tb_bus_arbiter;
  import bus_pkg::*;

  localparam int unsigned MAXB = 4;
  localparam logic [31:0] F_ADDR43 = 32'h0001_2000;
  localparam logic [31:0] D_ADDR43 = 32'h2000_0100;

  logic        clk, reset;
  logic        fetch_req, fetch_cancel, fetch_ready;
  logic [31:0] fetch_address, fetch_data;
  logic        data_req, data_write, data_ready;
  logic [31:0] data_address, data_wdata, data_rdata;
  logic [3:0]  data_strobe;
  logic        mem_valid, mem_ready;
  logic [31:0] mem_address, mem_wdata, mem_rdata;
  logic [3:0]  mem_strobe;

  bus_arbiter #(.MAX_DATA_BURST(MAXB)) dut (
    .clk(clk), .reset(reset),
    .fetch_req(fetch_req), .fetch_address(fetch_address), .fetch_cancel(fetch_cancel),
    .fetch_data(fetch_data), .fetch_ready(fetch_ready),
    .data_req(data_req), .data_write(data_write), .data_address(data_address),
    .data_wdata(data_wdata), .data_strobe(data_strobe),
    .data_rdata(data_rdata), .data_ready(data_ready),
    .mem_valid(mem_valid), .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_strobe(mem_strobe), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int          cyc;
    bit          is_fetch;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strobe;
  } bus_exp_t;

  typedef struct {
    int          cyc;
    bit          is_fetch;
    logic [31:0] fdata;
    logic [31:0] rdata;
  } resp_exp_t;

  bus_exp_t    exp_bus[$];
  resp_exp_t   exp_resp[$];
  logic [31:0] grant_log[$];

  // Memory contents: a fixed scramble of the address, optionally overridden
  bit          ovr_en  = 1'b0;
  logic [31:0] ovr_val = 32'h0;

  function automatic logic [31:0] rd_for(input logic [31:0] a);
    if (ovr_en) return ovr_val;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Reference model: one transaction at a time, one dead cycle after each completion
  int        cyc = 0;
  bit        m_busy = 1'b0, m_cool = 1'b0, m_cancel = 1'b0, m_write = 1'b0;
  bit        m_take_data;
  int        m_burst = 0;
  logic [31:0] m_fd = '0, m_dr = '0;
  bus_exp_t  m_cur;
  resp_exp_t m_r;

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      m_busy = 0; m_cool = 0; m_cancel = 0; m_burst = 0;
      m_fd = '0; m_dr = '0;
      exp_bus.delete();
      exp_resp.delete();
    end else if (m_cool) begin
      m_cool = 0;
    end else if (!m_busy) begin
      m_take_data = data_req && !(fetch_req && m_burst == int'(MAXB));
      if (m_take_data || fetch_req) begin
        m_cur.cyc      = cyc;
        m_cur.is_fetch = !m_take_data;
        m_write        = m_take_data && data_write;
        m_cur.addr     = m_take_data ? data_address : fetch_address;
        m_cur.wdata    = m_write ? data_wdata : 32'h0;
        m_cur.strobe   = m_write ? data_strobe : 4'h0;
        if (!m_take_data || !fetch_req) m_burst = 0;
        else if (m_burst < int'(MAXB)) m_burst = m_burst + 1;
        m_cancel = !m_take_data && fetch_cancel;
        exp_bus.push_back(m_cur);
        m_busy = 1;
      end
    end else begin
      if (m_cur.is_fetch && fetch_cancel) m_cancel = 1;
      if (mem_ready) begin
        m_busy = 0;
        m_cool = 1;
        if (m_cur.is_fetch) begin
          if (!m_cancel) begin
            m_fd = rd_for(m_cur.addr);
            m_r.cyc = cyc; m_r.is_fetch = 1; m_r.fdata = m_fd; m_r.rdata = m_dr;
            exp_resp.push_back(m_r);
          end
        end else begin
          if (!m_write) m_dr = rd_for(m_cur.addr);
          m_r.cyc = cyc; m_r.is_fetch = 0; m_r.fdata = m_fd; m_r.rdata = m_dr;
          exp_resp.push_back(m_r);
        end
      end
    end
  end

  // Memory responder: resp_mode 0 = delayed ready, 1 = never ready, 2 = always ready
  int resp_mode  = 0;
  int resp_delay = 0;
  bit noise      = 1'b0;
  bit acc_on     = 1'b0;
  int acc_wait   = 0;

  always @(negedge clk) begin
    if (resp_mode == 1) begin
      acc_on = 0; mem_ready = 1'b0;
    end else if (resp_mode == 2) begin
      acc_on = 0; mem_ready = 1'b1;
    end else if (mem_valid === 1'b1) begin
      if (!acc_on) begin
        acc_on   = 1;
        acc_wait = (resp_delay < 0) ? int'($urandom_range(0, 3)) : resp_delay;
      end
      if (acc_wait == 0) mem_ready = 1'b1;
      else begin
        mem_ready = 1'b0;
        acc_wait--;
      end
    end else begin
      acc_on    = 0;
      mem_ready = noise && ($urandom_range(0, 3) == 0);
    end
    mem_rdata = mem_ready ? rd_for(mem_address) : $urandom;
  end

  // Monitor: compares bus accesses and ready pulses against the model's queues
  bit       prev_valid = 1'b0;
  bit       have_bus = 1'b0;
  bus_exp_t cur_bus;
  resp_exp_t got_r;
  int       last_f = -100, last_d = -100;

  always @(negedge clk) begin
    if (mem_valid === 1'b1 && !prev_valid) begin
      grant_log.push_back(mem_address);
      if (exp_bus.size() == 0) begin
        total++; bad++; have_bus = 0;
        $display("FAIL unexpected_access: got addr %h want no access", mem_address);
      end else begin
        cur_bus  = exp_bus.pop_front();
        have_bus = 1;
        check("grant_cycle", 32'(cyc), 32'(cur_bus.cyc));
      end
    end
    if (mem_valid === 1'b1 && have_bus) begin
      check("mem_address", mem_address, cur_bus.addr);
      check("mem_wdata", mem_wdata, cur_bus.wdata);
      check("mem_strobe", 32'(mem_strobe), 32'(cur_bus.strobe));
    end
    if (fetch_ready === 1'b1 || data_ready === 1'b1) begin
      check("ready_exclusive", 32'(fetch_ready & data_ready), 32'h0);
      if (exp_resp.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_ready: got f=%b d=%b want none", fetch_ready, data_ready);
      end else begin
        got_r = exp_resp.pop_front();
        check("ready_cycle", 32'(cyc), 32'(got_r.cyc));
        check("ready_port", 32'(fetch_ready), 32'(got_r.is_fetch));
        check("fetch_data", fetch_data, got_r.fdata);
        check("data_rdata", data_rdata, got_r.rdata);
      end
      if (fetch_ready === 1'b1) begin
        check("fetch_ready_gap_ok", 32'(cyc - last_f >= 3), 32'h1);
        last_f = cyc;
      end
      if (data_ready === 1'b1) begin
        check("data_ready_gap_ok", 32'(cyc - last_d >= 3), 32'h1);
        last_d = cyc;
      end
    end
    prev_valid = (mem_valid === 1'b1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    fetch_req = 0; data_req = 0; fetch_cancel = 0;
    while ((m_busy || m_cool || exp_resp.size() != 0 || exp_bus.size() != 0) && n < 60) begin
      tick();
      n++;
    end
    tick(); tick();
    check("drain_within_bound", 32'(n < 60), 32'h1);
  endtask

  task automatic new_data();
    data_req     = 1;
    data_write   = 1'($urandom_range(0, 1));
    data_address = 32'h2000_0000 | ($urandom & 32'h0000_FFFC);
    data_wdata   = $urandom;
    data_strobe  = 4'($urandom_range(1, 15));
  endtask

  bit f_drop = 1'b0;

  task automatic step_random();
    fetch_cancel = 0;
    if (f_drop) begin
      fetch_req = 0;
      f_drop    = 0;
    end else if (fetch_req) begin
      if (fetch_ready) begin
        fetch_req     = ($urandom_range(0, 3) == 0);
        fetch_address = 32'h0001_0000 | ($urandom & 32'h0000_FFFC);
      end else if ($urandom_range(0, 19) == 0) begin
        fetch_cancel = 1;
        f_drop       = 1;
      end
    end else if ($urandom_range(0, 2) == 0) begin
      fetch_req     = 1;
      fetch_address = 32'h0001_0000 | ($urandom & 32'h0000_FFFC);
    end
    if (data_req) begin
      if (data_ready) begin
        if ($urandom_range(0, 2) == 0) new_data();
        else data_req = 0;
      end
    end else if ($urandom_range(0, 2) == 0) begin
      new_data();
    end
    tick();
  endtask

  initial begin
    int vcnt, rcnt, n;
    string seq;
    reset = 1; fetch_req = 0; fetch_address = 0; fetch_cancel = 0;
    data_req = 0; data_write = 0; data_address = 0; data_wdata = 0; data_strobe = 0;
    mem_ready = 0; mem_rdata = 0;
    repeat (3) tick();
    check("rst_mem_valid", 32'(mem_valid), 32'h0);
    check("rst_mem_address", mem_address, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_mem_strobe", 32'(mem_strobe), 32'h0);
    check("rst_readies", 32'({fetch_ready, data_ready}), 32'h0);
    check("rst_fetch_data", fetch_data, 32'h0);
    check("rst_data_rdata", data_rdata, 32'h0);
    check("rst_burst_cnt", 32'(dut.burst_cnt), 32'h0);
    reset = 0;
    tick();

    // Minimum-latency fetch
    ovr_en = 1; ovr_val = 32'h0000_0013; resp_delay = 0;
    fetch_req = 1; fetch_address = 32'h0001_1100;
    tick();
    check("min_mem_valid", 32'(mem_valid), 32'h1);
    check("min_mem_strobe", 32'(mem_strobe), 32'h0);
    check("min_mem_address", mem_address, 32'h0001_1100);
    tick();
    check("min_fetch_ready", 32'(fetch_ready), 32'h1);
    check("min_fetch_data", fetch_data, 32'h0000_0013);
    fetch_req = 0;
    drain();

    // Cancelled fetch completes on the bus silently, then a normal fetch
    ovr_val = 32'hFFFF_FFFF; resp_delay = 2;
    fetch_req = 1; fetch_address = 32'h0001_3000;
    tick();
    fetch_cancel = 1;
    tick();
    fetch_cancel = 0; fetch_req = 0;
    rcnt = 0; vcnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (fetch_ready) rcnt++;
      if (mem_valid) vcnt++;
      tick();
    end
    check("cancel_no_ready", 32'(rcnt), 32'h0);
    check("cancel_bus_done", 32'(mem_valid), 32'h0);
    check("cancel_bus_ran", 32'(vcnt > 0), 32'h1);
    check("cancel_fetch_data", fetch_data, 32'h0000_0013);
    ovr_val = 32'h0000_0093; resp_delay = 1;
    fetch_req = 1; fetch_address = 32'h0001_3004;
    n = 0;
    while (!fetch_ready && n < 20) begin tick(); n++; end
    fetch_req = 0;
    check("after_cancel_ready", 32'(fetch_ready), 32'h1);
    check("after_cancel_data", fetch_data, 32'h0000_0093);
    drain();
    ovr_en = 0;

    // Store with three wait cycles
    resp_delay = 3;
    data_req = 1; data_write = 1; data_address = 32'h0000_2000;
    data_wdata = 32'hDEAD_BEEF; data_strobe = 4'b0011;
    vcnt = 0; rcnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (mem_valid) vcnt++;
      if (data_ready) begin rcnt++; data_req = 0; end
    end
    check("store_valid_cycles", 32'(vcnt), 32'd4);
    check("store_ready_pulses", 32'(rcnt), 32'd1);
    check("store_rdata_kept", data_rdata, 32'h0);
    drain();

    // Reset in the second BUSY_DATA cycle abandons the access
    resp_mode = 1;
    data_req = 1; data_write = 0; data_address = 32'h2000_0040;
    fetch_req = 1; fetch_address = 32'h0001_4000;
    tick();
    tick();
    check("pre_reset_busy", 32'(mem_valid), 32'h1);
    reset = 1; data_req = 0; fetch_req = 0;
    tick();
    reset = 0; resp_mode = 2;
    check("rst_busy_mem_valid", 32'(mem_valid), 32'h0);
    check("rst_busy_readies", 32'({fetch_ready, data_ready}), 32'h0);
    check("rst_busy_burst_cnt", 32'(dut.burst_cnt), 32'h0);
    check("rst_busy_state", 32'(dut.state_q), 32'(ST_IDLE));
    rcnt = 0; vcnt = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (mem_valid) vcnt++;
      if (fetch_ready || data_ready) rcnt++;
    end
    check("late_ready_no_valid", 32'(vcnt), 32'h0);
    check("late_ready_no_pulse", 32'(rcnt), 32'h0);
    resp_mode = 0;
    drain();

    // Both requesters held high: data bursts of MAXB then one fetch
    resp_delay = -1;
    grant_log.delete();
    fetch_req = 1; fetch_address = F_ADDR43;
    data_req = 1; data_write = 0; data_address = D_ADDR43;
    n = 0;
    while (grant_log.size() < 10 && n < 200) begin tick(); n++; end
    while (!(fetch_ready || data_ready) && n < 220) begin tick(); n++; end
    drain();
    seq = "";
    for (int i = 0; i < 10 && i < grant_log.size(); i++)
      seq = {seq, (grant_log[i] == F_ADDR43) ? "F" : "D"};
    total++;
    if (seq != "DDDDFDDDDF") begin
      bad++;
      $display("FAIL grant_sequence: got %s want DDDDFDDDDF", seq);
    end

    // Randomized traffic with random memory latency and stray mem_ready
    noise = 1;
    for (int i = 0; i < 3000; i++) step_random();
    noise = 0;
    drain();
    check("resp_queue_empty", 32'(exp_resp.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
